// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-event signal bundle
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_value;
  logic       key_pressed;
  logic       key_strobe;

  // Scanner side: samples rows, drives columns and key events
  modport master (
    input  row_in,
    output col_out,
    output key_value,
    output key_pressed,
    output key_strobe
  );

  // Keypad/consumer side
  modport slave (
    output row_in,
    input  col_out,
    input  key_value,
    input  key_pressed,
    input  key_strobe
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_TICKS);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;

  logic [3:0]       row_m;
  logic [3:0]       row_s;
  logic [3:0]       row_cap;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       state;
  logic [1:0]       col_idx;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_inc;
  logic [3:0]       key_value_q;
  logic             key_pressed_q;
  logic             key_strobe_q;

  // True when exactly one row is pulled low; several low rows mean a ghost/multi-key
  function automatic logic one_low(input logic [3:0] r);
    case (r)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  // Key code for a single low row and the driven column
  function automatic logic [3:0] key_map(input logic [3:0] r, input logic [1:0] c);
    logic [1:0] ri;
    case (r)
      4'b1110: ri = 2'd0;
      4'b1101: ri = 2'd1;
      4'b1011: ri = 2'd2;
      default: ri = 2'd3;
    endcase
    case ({ri, c})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h2;
      4'h2: key_map = 4'h3;
      4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h6;
      4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;
      4'h9: key_map = 4'h8;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;
      4'hD: key_map = 4'h0;
      4'hE: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign tick    = (div_cnt == DIV_LAST);
  assign deb_inc = deb_cnt + DEB_W'(1);

  assign kp.col_out     = ~(4'b0001 << col_idx);
  assign kp.key_value   = key_value_q;
  assign kp.key_pressed = key_pressed_q;
  assign kp.key_strobe  = key_strobe_q;

  // Two-stage synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= kp.row_in;
      row_s <= row_m;
    end
  end

  // Free-running scan-tick divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Scan/debounce FSM, advanced only on scan ticks; strobe self-clears every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_SCAN;
      col_idx       <= 2'd0;
      deb_cnt       <= '0;
      row_cap       <= 4'hF;
      key_value_q   <= 4'h0;
      key_pressed_q <= 1'b0;
      key_strobe_q  <= 1'b0;
    end else begin
      key_strobe_q <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (row_s == 4'hF) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              row_cap <= row_s;
              if (DEBOUNCE_TICKS == 1) begin
                // A single sample is enough: accept immediately
                state   <= ST_PRESSED;
                deb_cnt <= '0;
                if (one_low(row_s)) begin
                  key_value_q   <= key_map(row_s, col_idx);
                  key_pressed_q <= 1'b1;
                  key_strobe_q  <= 1'b1;
                end
              end else begin
                deb_cnt <= DEB_W'(1);
                state   <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (row_s == row_cap) begin
              if (deb_inc == DEB_DONE) begin
                state   <= ST_PRESSED;
                deb_cnt <= '0;
                // Ghost patterns still wait for release but never report a key
                if (one_low(row_cap)) begin
                  key_value_q   <= key_map(row_cap, col_idx);
                  key_pressed_q <= 1'b1;
                  key_strobe_q  <= 1'b1;
                end
              end else begin
                deb_cnt <= deb_inc;
              end
            end else begin
              state   <= ST_SCAN;
              deb_cnt <= '0;
            end
          end
          ST_PRESSED: begin
            if (row_s == 4'hF) begin
              if (deb_inc == DEB_DONE) begin
                key_pressed_q <= 1'b0;
                col_idx       <= col_idx + 2'd1;
                state         <= ST_SCAN;
                deb_cnt       <= '0;
              end else begin
                deb_cnt <= deb_inc;
              end
            end else begin
              deb_cnt <= '0;
            end
          end
          default: begin
            state   <= ST_SCAN;
            deb_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
